// File: rtl/branch_unit_ras.sv
// branch_unit_ras
//   Next-PC generation and branch resolution for the RISC core. Owns the
//   fetch PC, a latched N/Z/C flag register and a circular return-address
//   stack (RAS) used by bl (call) and ret (return).
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous active-low reset
//   stall          holds pc, RAS and taken; flags still capture
//   instr_valid    decode slot holds a real instruction
//   branch         class: 00 none, 01 reg/cond-flag, 10 uncond/carry, 11 link
//   function_code  sub-operation within the class
//   reg1_value     register target for br
//   branch_address immediate/absolute target
//   alu_negative/alu_zero/alu_carry  ALU flags, valid when flag_we=1
//   flag_we        capture ALU flags this cycle (also bypassed into decode)
//   pc             registered fetch address
//   pc_plus1       pc+1, combinational, wraps
//   taken          registered, high for the cycle after a taken redirect
//   ras_empty/ras_full  RAS occupancy
//   ras_err        sticky RAS overflow/underflow flag
//   br_count/taken_count  statistics counters (only with BRANCH_UNIT_STATS_EN)
//
// Optional feature: define BRANCH_UNIT_STATS_EN to add saturating counters of
// accepted branch-class instructions and taken redirects.

module branch_unit_ras #(
  parameter int unsigned           PC_W      = 32,
  parameter int unsigned           RAS_DEPTH = 8,
  parameter logic [PC_W-1:0]       RESET_PC  = '0,
  parameter int unsigned           STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic [1:0]        branch,
  input  logic [5:0]        function_code,
  input  logic [PC_W-1:0]   reg1_value,
  input  logic [PC_W-1:0]   branch_address,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              flag_we,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus1,
  output logic              taken,
  output logic              ras_empty,
  output logic              ras_full,
`ifdef BRANCH_UNIT_STATS_EN
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] taken_count,
`endif
  output logic              ras_err
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0 || STAT_W < 1) begin : g_bad_params
    $error("branch_unit_ras: RAS_DEPTH must be a power of two >= 2 and STAT_W >= 1");
  end

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             taken_q, taken_d;
  logic [2:0]       flags_q;            // {N, Z, C}
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;              // next free slot; ptr_q-1 is top of stack
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic             eff_n, eff_z, eff_c;
  logic             accept, take, push, pop, underflow;
  logic [PC_W-1:0]  target;
  logic [PTR_W-1:0] ptr_dec;
  logic             full;

  assign pc_plus1 = pc_q + PC_W'(1);
  assign ptr_dec  = ptr_q - PTR_W'(1);
  assign full     = (cnt_q == CNT_W'(RAS_DEPTH));

  // Same-cycle ALU flags take priority over the latched copy.
  assign eff_n = flag_we ? alu_negative : flags_q[2];
  assign eff_z = flag_we ? alu_zero     : flags_q[1];
  assign eff_c = flag_we ? alu_carry    : flags_q[0];

  assign accept = instr_valid & ~stall;

  always_comb begin
    take      = 1'b0;
    target    = branch_address;
    push      = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    if (accept) begin
      case ({branch, function_code})
        8'b01_000000: begin take = 1'b1; target = reg1_value; end
        8'b01_000001: take = eff_n;
        8'b01_000010: take = eff_z;
        8'b01_000011: take = ~eff_z;
        8'b10_000000: take = 1'b1;
        8'b10_000001: take = eff_c;
        8'b10_000010: take = ~eff_c;
        8'b11_000000: begin take = 1'b1; push = 1'b1; end
        8'b11_000001: begin
          // Return on an empty stack falls through and flags the error.
          if (cnt_q != '0) begin
            take   = 1'b1;
            pop    = 1'b1;
            target = ras_q[ptr_dec];
          end else begin
            underflow = 1'b1;
          end
        end
        default: take = 1'b0;
      endcase
    end
    pc_d    = stall ? pc_q    : (take ? target : pc_plus1);
    taken_d = stall ? taken_q : take;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      flags_q <= 3'b000;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      if (flag_we) flags_q <= {alu_negative, alu_zero, alu_carry};
      if (push) begin
        ptr_q <= ptr_q + PTR_W'(1);
        // When full the push lands on the oldest slot; occupancy saturates.
        if (full) err_q <= 1'b1;
        else      cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        ptr_q <= ptr_dec;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (underflow) err_q <= 1'b1;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= pc_plus1;
  end

`ifdef BRANCH_UNIT_STATS_EN
  logic [STAT_W-1:0] br_cnt_q, tk_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      if (accept && branch != 2'b00 && br_cnt_q != '1) br_cnt_q <= br_cnt_q + STAT_W'(1);
      if (take && tk_cnt_q != '1) tk_cnt_q <= tk_cnt_q + STAT_W'(1);
    end
  end

  assign br_count    = br_cnt_q;
  assign taken_count = tk_cnt_q;
`endif

  assign pc        = pc_q;
  assign taken     = taken_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = full;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_branch_unit_ras.sv
module tb_branch_unit_ras;
  localparam int PC_W      = 32;
  localparam int RAS_DEPTH = 8;
  localparam int STAT_W    = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            instr_valid;
  logic [1:0]      branch;
  logic [5:0]      function_code;
  logic [PC_W-1:0] reg1_value;
  logic [PC_W-1:0] branch_address;
  logic            alu_negative, alu_zero, alu_carry, flag_we;
  logic [PC_W-1:0] pc, pc_plus1;
  logic            taken, ras_empty, ras_full, ras_err;
`ifdef BRANCH_UNIT_STATS_EN
  logic [STAT_W-1:0] br_count, taken_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_unit_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC('0), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid),
    .branch(branch), .function_code(function_code),
    .reg1_value(reg1_value), .branch_address(branch_address),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .flag_we(flag_we), .pc(pc), .pc_plus1(pc_plus1), .taken(taken),
    .ras_empty(ras_empty), .ras_full(ras_full),
`ifdef BRANCH_UNIT_STATS_EN
    .br_count(br_count), .taken_count(taken_count),
`endif
    .ras_err(ras_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [1:0] b, input logic [5:0] fc,
                           input logic [PC_W-1:0] addr, input logic [PC_W-1:0] r1);
    instr_valid    = v;
    branch         = b;
    function_code  = fc;
    branch_address = addr;
    reg1_value     = r1;
  endtask

  task automatic set_flags(input logic we, input logic n, input logic z, input logic c);
    flag_we = we; alu_negative = n; alu_zero = z; alu_carry = c;
  endtask

  task automatic test_reset;
    rst = 1'b0; stall = 1'b0;
    set_instr(1'b0, 2'b00, 6'd0, '0, '0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    total++; if (pc_plus1 !== 32'h1) begin bad++; $display("FAIL reset_pc_plus1: got %h want %h", pc_plus1, 32'h1); end
    total++; if ({taken, ras_empty, ras_full, ras_err} !== 4'b0100) begin
      bad++; $display("FAIL reset_status: got %b want %b", {taken, ras_empty, ras_full, ras_err}, 4'b0100);
    end
    tick;
    rst = 1'b1;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_release_pc: got %h want %h", pc, 32'h0); end
  endtask

  task automatic test_fallthrough;
    set_instr(1'b1, 2'b00, 6'd0, 32'h999, 32'h888);
    for (int i = 1; i <= 5; i++) begin
      tick;
      total++; if (pc !== PC_W'(i) || taken !== 1'b0) begin
        bad++; $display("FAIL fall_pc%0d: got pc=%h taken=%b want pc=%h taken=0", i, pc, taken, PC_W'(i));
      end
    end
  endtask

  // Starts at pc=5.
  task automatic test_flag_bypass;
    set_flags(1'b1, 1'b0, 1'b1, 1'b0);
    set_instr(1'b1, 2'b01, 6'b000010, 32'h40, '0);            // bz, Z bypassed
    tick;
    total++; if (pc !== 32'h40 || taken !== 1'b1) begin
      bad++; $display("FAIL bz_bypass: got pc=%h taken=%b want pc=40 taken=1", pc, taken);
    end
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);                         // latch Z=0
    set_instr(1'b1, 2'b00, 6'd0, '0, '0);
    tick;
    total++; if (pc !== 32'h41 || taken !== 1'b0) begin
      bad++; $display("FAIL latch_z0: got pc=%h taken=%b want pc=41 taken=0", pc, taken);
    end
    set_flags(1'b0, 1'b1, 1'b1, 1'b1);                         // ignored, flag_we=0
    set_instr(1'b1, 2'b01, 6'b000010, 32'h40, '0);             // bz with latched Z=0
    tick;
    total++; if (pc !== 32'h42 || taken !== 1'b0) begin
      bad++; $display("FAIL bz_latched: got pc=%h taken=%b want pc=42 taken=0", pc, taken);
    end
    set_instr(1'b1, 2'b01, 6'b000011, 32'h50, '0);             // bnz
    tick;
    total++; if (pc !== 32'h50 || taken !== 1'b1) begin
      bad++; $display("FAIL bnz: got pc=%h taken=%b want pc=50 taken=1", pc, taken);
    end
    set_instr(1'b1, 2'b01, 6'b000001, 32'h60, '0);             // bltz, N latched 0
    tick;
    total++; if (pc !== 32'h51 || taken !== 1'b0) begin
      bad++; $display("FAIL bltz_nt: got pc=%h taken=%b want pc=51 taken=0", pc, taken);
    end
    set_flags(1'b1, 1'b1, 1'b0, 1'b0);
    tick;                                                      // bltz, N bypassed 1
    total++; if (pc !== 32'h60 || taken !== 1'b1) begin
      bad++; $display("FAIL bltz_t: got pc=%h taken=%b want pc=60 taken=1", pc, taken);
    end
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);                         // clear N, C=0
    set_instr(1'b1, 2'b01, 6'b000111, 32'h70, '0);             // undefined code
    tick;
    total++; if (pc !== 32'h61 || taken !== 1'b0) begin
      bad++; $display("FAIL bad_code: got pc=%h taken=%b want pc=61 taken=0", pc, taken);
    end
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_carry_and_uncond;
    set_instr(1'b1, 2'b10, 6'b000010, 32'h20, '0);             // bncy, C=0
    tick;
    total++; if (pc !== 32'h20 || taken !== 1'b1) begin
      bad++; $display("FAIL bncy: got pc=%h taken=%b want pc=20 taken=1", pc, taken);
    end
    set_instr(1'b1, 2'b10, 6'b000001, 32'h20, '0);             // bcy, C=0
    tick;
    total++; if (pc !== 32'h21 || taken !== 1'b0) begin
      bad++; $display("FAIL bcy_nt: got pc=%h taken=%b want pc=21 taken=0", pc, taken);
    end
    set_instr(1'b1, 2'b01, 6'b000000, 32'h77, 32'h1234);       // br via register
    tick;
    total++; if (pc !== 32'h1234 || taken !== 1'b1) begin
      bad++; $display("FAIL br_reg: got pc=%h taken=%b want pc=1234 taken=1", pc, taken);
    end
    set_instr(1'b0, 2'b10, 6'b000000, 32'h99, '0);             // b, but not valid
    tick;
    total++; if (pc !== 32'h1235 || taken !== 1'b0) begin
      bad++; $display("FAIL invalid_b: got pc=%h taken=%b want pc=1235 taken=0", pc, taken);
    end
    set_instr(1'b1, 2'b10, 6'b000000, 32'h10, '0);             // b
    tick;
    total++; if (pc !== 32'h10 || taken !== 1'b1) begin
      bad++; $display("FAIL b: got pc=%h taken=%b want pc=10 taken=1", pc, taken);
    end
  endtask

  // Starts at pc=0x10.
  task automatic test_call_ret;
    set_instr(1'b1, 2'b11, 6'b000000, 32'h100, '0);            // bl
    tick;
    total++; if (pc !== 32'h100 || taken !== 1'b1 || ras_empty !== 1'b0) begin
      bad++; $display("FAIL bl: got pc=%h taken=%b empty=%b want pc=100 taken=1 empty=0", pc, taken, ras_empty);
    end
    set_instr(1'b1, 2'b00, 6'd0, '0, '0);
    repeat (5) tick;
    total++; if (pc !== 32'h105) begin bad++; $display("FAIL pre_ret_pc: got %h want %h", pc, 32'h105); end
    set_instr(1'b1, 2'b11, 6'b000001, 32'hdead, '0);           // ret
    tick;
    total++; if (pc !== 32'h11 || taken !== 1'b1 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
      bad++; $display("FAIL ret: got pc=%h taken=%b empty=%b err=%b want pc=11 taken=1 empty=1 err=0",
                      pc, taken, ras_empty, ras_err);
    end
  endtask

  // Starts at pc=0x11.
  task automatic test_ras_overflow;
    logic [PC_W-1:0] exp_ret;
    for (int i = 0; i <= RAS_DEPTH; i++) begin
      set_instr(1'b1, 2'b11, 6'b000000, PC_W'(32'h200 + 32'h10 * i), '0);
      tick;
      if (i == RAS_DEPTH - 1) begin
        total++; if (ras_full !== 1'b1 || ras_err !== 1'b0) begin
          bad++; $display("FAIL ras_full_exact: got full=%b err=%b want full=1 err=0", ras_full, ras_err);
        end
      end
    end
    total++; if (ras_full !== 1'b1 || ras_err !== 1'b1 || pc !== 32'h280) begin
      bad++; $display("FAIL ras_overflow: got full=%b err=%b pc=%h want full=1 err=1 pc=280", ras_full, ras_err, pc);
    end
    // Pushed values were 0x12, 0x201, 0x211 .. 0x271; 0x12 was overwritten.
    for (int k = 0; k < RAS_DEPTH; k++) begin
      exp_ret = PC_W'(32'h271 - 32'h10 * k);
      set_instr(1'b1, 2'b11, 6'b000001, 32'hbad, '0);
      tick;
      total++; if (pc !== exp_ret || taken !== 1'b1) begin
        bad++; $display("FAIL ras_pop%0d: got pc=%h taken=%b want pc=%h taken=1", k, pc, taken, exp_ret);
      end
    end
    total++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      bad++; $display("FAIL ras_drained: got empty=%b full=%b want empty=1 full=0", ras_empty, ras_full);
    end
    tick;                                                      // extra ret at 0x201
    total++; if (pc !== 32'h202 || taken !== 1'b0 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin
      bad++; $display("FAIL ras_underflow: got pc=%h taken=%b err=%b empty=%b want pc=202 taken=0 err=1 empty=1",
                      pc, taken, ras_err, ras_empty);
    end
  endtask

  // Starts at pc=0x202.
  task automatic test_stall;
    stall = 1'b1;
    set_instr(1'b1, 2'b10, 6'b000000, 32'h80, '0);            // b held under stall
    set_flags(1'b1, 1'b0, 1'b0, 1'b1);                         // C latches despite stall
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (pc !== 32'h202 || taken !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: got pc=%h taken=%b want pc=202 taken=0", i, pc, taken);
      end
      set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    end
    stall = 1'b0;
    tick;
    total++; if (pc !== 32'h80 || taken !== 1'b1) begin
      bad++; $display("FAIL stall_release: got pc=%h taken=%b want pc=80 taken=1", pc, taken);
    end
    set_instr(1'b1, 2'b10, 6'b000001, 32'h90, '0);             // bcy, C latched during stall
    tick;
    total++; if (pc !== 32'h90 || taken !== 1'b1) begin
      bad++; $display("FAIL flag_in_stall: got pc=%h taken=%b want pc=90 taken=1", pc, taken);
    end
    stall = 1'b1;
    set_instr(1'b0, 2'b00, 6'd0, '0, '0);
    tick;
    total++; if (pc !== 32'h90 || taken !== 1'b1) begin
      bad++; $display("FAIL stall_taken_hold: got pc=%h taken=%b want pc=90 taken=1", pc, taken);
    end
    stall = 1'b0;
  endtask

  task automatic test_pc_wrap;
    set_instr(1'b1, 2'b01, 6'b000000, '0, 32'hFFFF_FFFF);     // br to all-ones
    tick;
    total++; if (pc !== 32'hFFFF_FFFF || pc_plus1 !== 32'h0) begin
      bad++; $display("FAIL wrap_top: got pc=%h pc_plus1=%h want pc=ffffffff pc_plus1=0", pc, pc_plus1);
    end
    set_instr(1'b1, 2'b00, 6'd0, '0, '0);
    tick;
    total++; if (pc !== 32'h0 || taken !== 1'b0) begin
      bad++; $display("FAIL wrap_zero: got pc=%h taken=%b want pc=0 taken=0", pc, taken);
    end
  endtask

  // Starts at pc=0; ras_err still set from the underflow above.
  task automatic test_async_reset;
    set_instr(1'b1, 2'b11, 6'b000000, 32'h300, '0);            // bl, RAS non-empty
    tick;
    set_instr(1'b1, 2'b00, 6'd0, '0, '0);
    #2;
    rst = 1'b0;                                                // mid-cycle, no edge
    #1;
    total++; if (pc !== 32'h0 || taken !== 1'b0 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
      bad++; $display("FAIL async_reset: got pc=%h taken=%b empty=%b err=%b want pc=0 taken=0 empty=1 err=0",
                      pc, taken, ras_empty, ras_err);
    end
    tick;
    rst = 1'b1;
    set_instr(1'b1, 2'b11, 6'b000001, '0, '0);                 // ret must find nothing
    tick;
    total++; if (pc !== 32'h1 || taken !== 1'b0 || ras_err !== 1'b1) begin
      bad++; $display("FAIL ret_after_reset: got pc=%h taken=%b err=%b want pc=1 taken=0 err=1", pc, taken, ras_err);
    end
  endtask

  initial begin
    test_reset;
    test_fallthrough;
    test_flag_bypass;
    test_carry_and_uncond;
    test_call_ret;
    test_ras_overflow;
    test_stall;
    test_pc_wrap;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
